// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing and helpers for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

  localparam int REG_WIDTH  = 16;
  localparam int NUM_REGS   = 16;
  localparam int IDX_WIDTH  = 4;
  localparam int CNT_WIDTH  = 5;

  // Number of set bits in a busy vector (0..NUM_REGS).
  function automatic logic [CNT_WIDTH-1:0] busy_popcount(input logic [NUM_REGS-1:0] vec);
    logic [CNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + {{(CNT_WIDTH-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// In-flight tracking: busy bits with issue-over-writeback priority,
// sticky writeback error, and registered pending count.
module regfile_scoreboard_busy
  import regfile_scoreboard_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 lock_i,
  input  logic                 issue_set_i,
  input  logic [IDX_WIDTH-1:0] issue_idx_i,
  input  logic                 wb_en_i,
  input  logic [IDX_WIDTH-1:0] wb_idx_i,
  output logic [NUM_REGS-1:0]  busy_o,
  output logic [NUM_REGS-1:0]  eff_busy_o,
  output logic [CNT_WIDTH-1:0] pending_o,
  output logic                 wb_error_o
);

  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [CNT_WIDTH-1:0] pending_q, pending_d;
  logic                 wb_error_q, wb_error_d;
  logic [NUM_REGS-1:0]  wb_mask;
  logic                 wb_fire;
  logic                 iss_fire;

  assign wb_fire  = lock_i && wb_en_i;
  assign iss_fire = lock_i && issue_set_i;

  // One-hot of the register being written back this cycle (zero if none).
  always_comb begin
    wb_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_fire && (wb_idx_i == IDX_WIDTH'(i))) wb_mask[i] = 1'b1;
    end
  end

  // Next busy state: clear on writeback first, then issue set wins.
  always_comb begin
    busy_d     = busy_q & ~wb_mask;
    wb_error_d = wb_error_q;
    if (wb_fire && !busy_q[wb_idx_i]) wb_error_d = 1'b1;
    if (iss_fire) busy_d[issue_idx_i] = 1'b1;
    pending_d = busy_popcount(busy_d);
  end

  // State registers; with lock low the _d values equal the _q values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q     <= '0;
      pending_q  <= '0;
      wb_error_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      wb_error_q <= wb_error_d;
    end
  end

  assign busy_o     = busy_q;
  assign eff_busy_o = busy_q & ~wb_mask;
  assign pending_o  = pending_q;
  assign wb_error_o = wb_error_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with writeback bypass on both read ports
// and a RAW/WAW dependency stall for Decode.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                 I_CLOCK,
  input  logic                 I_RESET_N,
  input  logic                 I_LOCK,
  input  logic                 I_IssueValid,
  input  logic                 I_IssueWritesDest,
  input  logic [IDX_WIDTH-1:0] I_IssueDestIdx,
  input  logic [IDX_WIDTH-1:0] I_Src1Idx,
  input  logic                 I_Src1Used,
  input  logic [IDX_WIDTH-1:0] I_Src2Idx,
  input  logic                 I_Src2Used,
  input  logic [IDX_WIDTH-1:0] I_DestIdx,
  input  logic                 I_DestUsed,
  input  logic                 I_WriteBackEnable,
  input  logic [IDX_WIDTH-1:0] I_WriteBackRegIdx,
  input  logic [REG_WIDTH-1:0] I_WriteBackData,
  output logic [REG_WIDTH-1:0] O_Src1Value,
  output logic [REG_WIDTH-1:0] O_Src2Value,
  output logic                 O_DepStallSignal,
  output logic [NUM_REGS-1:0]  O_BusyVec,
  output logic [CNT_WIDTH-1:0] O_PendingCount,
  output logic                 O_WbError
);

  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]  eff_busy;
  logic                 wb_fire;

  assign wb_fire = I_WriteBackEnable && I_LOCK;

  regfile_scoreboard_busy u_busy (
    .clk_i       (I_CLOCK),
    .rst_n_i     (I_RESET_N),
    .lock_i      (I_LOCK),
    .issue_set_i (I_IssueValid && I_IssueWritesDest),
    .issue_idx_i (I_IssueDestIdx),
    .wb_en_i     (I_WriteBackEnable),
    .wb_idx_i    (I_WriteBackRegIdx),
    .busy_o      (O_BusyVec),
    .eff_busy_o  (eff_busy),
    .pending_o   (O_PendingCount),
    .wb_error_o  (O_WbError)
  );

  // Data array: writeback always lands, regardless of busy state.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_fire) begin
      regs_q[I_WriteBackRegIdx] <= I_WriteBackData;
    end
  end

  // Read ports with write-before-read bypass.
  always_comb begin
    O_Src1Value = regs_q[I_Src1Idx];
    O_Src2Value = regs_q[I_Src2Idx];
    if (wb_fire && (I_WriteBackRegIdx == I_Src1Idx)) O_Src1Value = I_WriteBackData;
    if (wb_fire && (I_WriteBackRegIdx == I_Src2Idx)) O_Src2Value = I_WriteBackData;
  end

  // Hazard check against the post-writeback busy view.
  always_comb begin
    O_DepStallSignal = I_LOCK &&
                       ((I_Src1Used && eff_busy[I_Src1Idx]) ||
                        (I_Src2Used && eff_busy[I_Src2Idx]) ||
                        (I_DestUsed && eff_busy[I_DestIdx]));
  end

endmodule
